cpu_clock_ctrl: RTL

- Sequences CPU advancement from the single 50 MHz board clock.
- Owns a programmable prescaler that produces a periodic scan tick (500 Hz by default) for display multiplexing and for button sampling.
- Produces a one-cycle CPU clock-enable pulse in one of three modes: free-run at the tick rate, single-step from a debounced push-button, or halt.
- Sits between the board I/O and the pipelined CPU. The CPU stalls whenever cpu_en is low.

---
 rtl/cpu_clock_ctrl_pkg.sv | 23 ++
 rtl/cpu_clock_ctrl_step_debouncer.sv | 51 +++++
 rtl/cpu_clock_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/cpu_clock_ctrl_pkg.sv
// cpu_clock_ctrl_pkg
//   Shared encodings for the CPU clock controller: FSM state values (also
//   shown on the debug display), the mode selector encoding, the reset tick
//   period and the smallest period a div_load may program.
package cpu_clock_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT      = 2'd0,
    RUN       = 2'd1,
    STEP_IDLE = 2'd2,
    STEP_WAIT = 2'd3
  } state_t;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  // 50 MHz / 100000 = 500 Hz scan tick
  localparam int DEFAULT_DIV = 100000;
  // A period of 0 or 1 would never produce a distinct wrap cycle
  localparam int DIV_MIN     = 2;

endpackage

// File: rtl/cpu_clock_ctrl_step_debouncer.sv
// step_debouncer
//   Two-flop synchronizer for the raw step button followed by a debouncer
//   that only samples on scan_tick. The debounced level flips after
//   DEB_SAMPLES consecutive tick samples disagree with it.
// Ports:
//   clk_50MHz  in   system clock
//   reset      in   synchronous active-high reset
//   scan_tick  in   sample strobe
//   step_btn   in   raw asynchronous push-button
//   btn_deb    out  debounced level (1 = pressed)
module step_debouncer #(
  parameter int DEB_SAMPLES = 4
) (
  input  logic clk_50MHz,
  input  logic reset,
  input  logic scan_tick,
  input  logic step_btn,
  output logic btn_deb
);

  localparam int RUN_W = $clog2(DEB_SAMPLES + 1);

  logic             sync1, btn_s;
  logic [RUN_W-1:0] run;

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      sync1   <= 1'b0;
      btn_s   <= 1'b0;
      btn_deb <= 1'b0;
      run     <= '0;
    end else begin
      sync1 <= step_btn;
      btn_s <= sync1;
      if (scan_tick) begin
        if (btn_s != btn_deb) begin
          // Last disagreeing sample of the run: commit the new level
          if (run == RUN_W'(DEB_SAMPLES - 1)) begin
            btn_deb <= btn_s;
            run     <= '0;
          end else begin
            run <= run + 1'b1;
          end
        end else begin
          run <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl
//   Programmable prescaler producing scan_tick, plus the CPU advance FSM
//   (halt / free-run / single-step) producing a one-cycle cpu_en.
// Ports:
//   clk_50MHz   in   sole clock
//   reset       in   synchronous active-high reset
//   div_load    in   strobe capturing div_value into the pending period
//   div_value   in   requested tick period in cycles (0/1 clamp to 2)
//   mode        in   00 halt, 01 run, 10 step, 11 halt
//   step_btn    in   raw push-button
//   scan_tick   out  one-cycle pulse per period
//   cpu_en      out  one-cycle CPU advance enable
//   step_count  out  number of cpu_en pulses issued (wraps)
//   state       out  FSM state for debug display
module cpu_clock_ctrl #(
  parameter int DIV_WIDTH   = 17,
  parameter int DEFAULT_DIV = cpu_clock_ctrl_pkg::DEFAULT_DIV,
  parameter int DEB_SAMPLES = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk_50MHz,
  input  logic                 reset,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic [1:0]           mode,
  input  logic                 step_btn,
  output logic                 scan_tick,
  output logic                 cpu_en,
  output logic [CNT_WIDTH-1:0] step_count,
  output logic [1:0]           state
);

  import cpu_clock_ctrl_pkg::*;

  logic [DIV_WIDTH-1:0] cnt, period, pending;
  logic [DIV_WIDTH-1:0] cnt_nxt, period_nxt;
  logic                 wrap;
  logic                 btn_deb;
  state_t               state_q;

  // Prescaler: the period only changes on the wrap edge, so the running
  // period always completes. scan_tick is registered from the next-state
  // view so it is high exactly while cnt == period-1.
  always_comb begin
    wrap       = (cnt == period - 1'b1);
    cnt_nxt    = wrap ? '0 : cnt + 1'b1;
    period_nxt = wrap ? pending : period;
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      cnt       <= '0;
      period    <= DIV_WIDTH'(DEFAULT_DIV);
      pending   <= DIV_WIDTH'(DEFAULT_DIV);
      scan_tick <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      period    <= period_nxt;
      scan_tick <= (cnt_nxt == period_nxt - 1'b1);
      if (div_load)
        pending <= (div_value < DIV_WIDTH'(DIV_MIN)) ? DIV_WIDTH'(DIV_MIN) : div_value;
    end
  end

  step_debouncer #(
    .DEB_SAMPLES (DEB_SAMPLES)
  ) u_deb (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .scan_tick (scan_tick),
    .step_btn  (step_btn),
    .btn_deb   (btn_deb)
  );

  // Mode is evaluated before the button every cycle, so a mode change in
  // the same cycle as a press swallows the step pulse. Entering step mode
  // with the button already held parks in STEP_WAIT until it is released.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q    <= HALT;
      cpu_en     <= 1'b0;
      step_count <= '0;
    end else begin
      cpu_en     <= 1'b0;
      step_count <= step_count + CNT_WIDTH'(cpu_en);
      case (state_q)
        HALT, RUN: begin
          if (mode == MODE_RUN) begin
            state_q <= RUN;
            cpu_en  <= (state_q == RUN) && scan_tick;
          end else if (mode == MODE_STEP) begin
            state_q <= btn_deb ? STEP_WAIT : STEP_IDLE;
          end else begin
            state_q <= HALT;
          end
        end
        STEP_IDLE, STEP_WAIT: begin
          if (mode == MODE_RUN) begin
            state_q <= RUN;
          end else if (mode != MODE_STEP) begin
            state_q <= HALT;
          end else if (state_q == STEP_IDLE && btn_deb) begin
            cpu_en  <= 1'b1;
            state_q <= STEP_WAIT;
          end else if (state_q == STEP_WAIT && !btn_deb) begin
            state_q <= STEP_IDLE;
          end
        end
        default: state_q <= HALT;
      endcase
    end
  end

  assign state = state_q;

endmodule
